// File: rtl/mem_arb_pkg.sv
// Shared types and default timing constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    ID_IF,
    ID_DM
  } arb_id_t;

  localparam int unsigned MEM_LAT_DEF    = 2;
  localparam int unsigned STARVE_LIM_DEF = 4;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter timing one memory access; o_zero marks the final BUSY cycle.
module mem_arb_lat_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF and MEM requesters and drives pipe_stall.
// Define ARB_PERF_EN to add the perf_stall_cnt / perf_if_starve counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pipe_stall
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [15:0]       perf_if_starve
`endif
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned SC_W  = $clog2(STARVE_LIM + 1);

  arb_state_t        r_state, w_state_nxt;
  arb_id_t           r_id;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_if_done, r_dm_done;
  logic [31:0]       r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic [SC_W-1:0]   r_starve;
  logic              w_grant, w_pick_if, w_starved, w_lat_zero, w_last;

  assign w_starved = (r_starve == SC_W'(STARVE_LIM));
  assign w_pick_if = if_req & (~dm_req | w_starved);
  assign w_last    = (r_state == BUSY) & w_lat_zero;

  mem_arb_lat_cnt #(.W(CNT_W)) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_grant),
    .i_load_val (CNT_W'(MEM_LAT - 1)),
    .i_dec      (r_state == BUSY),
    .o_zero     (w_lat_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (if_req || dm_req) begin
          w_grant     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_lat_zero) w_state_nxt = RESP;
      end
      RESP: begin
        // Regrant straight from RESP so back-to-back accesses see no idle bubble.
        if (if_req || dm_req) begin
          w_grant     = 1'b1;
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_id       <= ID_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_done  <= 1'b0;
      r_dm_done  <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_starve   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_if_done <= w_last && (r_id == ID_IF);
      r_dm_done <= w_last && (r_id == ID_DM);
      if (w_last && !r_we) begin
        if (r_id == ID_IF) r_if_rdata <= mem_rdata[31:0];
        else               r_dm_rdata <= mem_rdata;
      end
      if (w_grant) begin
        if (w_pick_if) begin
          r_id     <= ID_IF;
          r_we     <= 1'b0;
          r_addr   <= if_addr;
          r_wdata  <= '0;
          r_starve <= '0;
        end else begin
          r_id    <= ID_DM;
          r_we    <= dm_we;
          r_addr  <= dm_addr;
          r_wdata <= dm_wdata;
          if (if_req && !w_starved) r_starve <= r_starve + 1'b1;
        end
      end
    end
  end

  assign mem_en     = (r_state == BUSY);
  assign mem_we     = mem_en & r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign if_done    = r_if_done;
  assign dm_done    = r_dm_done;
  assign if_rdata   = r_if_rdata;
  assign dm_rdata   = r_dm_rdata;
  assign pipe_stall = rst & ((if_req & ~r_if_done) | (dm_req & ~r_dm_done));

`ifdef ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_starve;

  // An IF grant while DM is also requesting can only come from the starvation override.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall  <= '0;
      r_perf_starve <= '0;
    end else begin
      if (pipe_stall) r_perf_stall <= r_perf_stall + 1'b1;
      if (w_grant && w_pick_if && dm_req) r_perf_starve <= r_perf_starve + 1'b1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_if_starve = r_perf_starve;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected accesses and read data queued at drive time.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_LIM = 4;
  localparam int unsigned TMO        = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [63:0] if_addr, dm_addr, dm_wdata;
  logic        if_done, dm_done, mem_en, mem_we, pipe_stall;
  logic [31:0] if_rdata;
  logic [63:0] dm_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_if_starve;
`endif

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } acc_t;

  acc_t        order_q[$];
  logic [63:0] if_q[$];
  logic [63:0] dm_q[$];
  int unsigned start_q[$];
  logic [63:0] tb_mem [0:255];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned tb_stall = 0;

  mem_port_arbiter #(
    .ADDR_W     (64),
    .DATA_W     (64),
    .MEM_LAT    (MEM_LAT),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_done    (if_done),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_done    (dm_done),
    .dm_rdata   (dm_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pipe_stall (pipe_stall)
`ifdef ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_if_starve (perf_if_starve)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem_en ? tb_mem[mem_addr[10:3]] : '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  // Bus monitor: access order/shape, write-back into the memory model, done/rdata scoreboard.
  initial begin
    acc_t        cur;
    logic        prev_en;
    int unsigned en_cnt, we_cnt;
    cur     = '{we: 1'b0, addr: '0, wdata: '0};
    prev_en = 1'b0;
    en_cnt  = 0;
    we_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_en = 1'b0;
        en_cnt  = 0;
        we_cnt  = 0;
      end else begin
        if (mem_en && !prev_en) begin
          chk("acc_expected", 64'(order_q.size() != 0), 64'd1);
          if (order_q.size() != 0) begin
            cur = order_q.pop_front();
            chk("acc_we", 64'(mem_we), 64'(cur.we));
            chk("acc_addr", mem_addr, cur.addr);
            if (cur.we) chk("acc_wdata", mem_wdata, cur.wdata);
          end
          start_q.push_back(cyc);
          en_cnt = 0;
          we_cnt = 0;
        end
        if (mem_en) begin
          en_cnt++;
          if (mem_we) begin
            we_cnt++;
            tb_mem[mem_addr[10:3]] = mem_wdata;
          end
        end
        if (!mem_en && prev_en) begin
          chk("busy_len", 64'(en_cnt), 64'(MEM_LAT));
          chk("we_len", 64'(we_cnt), cur.we ? 64'(MEM_LAT) : 64'd0);
        end
        if (if_done) begin
          chk("if_done_expected", 64'(if_q.size() != 0), 64'd1);
          if (if_q.size() != 0) chk("if_rdata", 64'(if_rdata), if_q.pop_front());
        end
        if (dm_done) begin
          chk("dm_done_expected", 64'(dm_q.size() != 0), 64'd1);
          if (dm_q.size() != 0) chk("dm_rdata", dm_rdata, dm_q.pop_front());
        end
        prev_en = mem_en;
      end
    end
  end

  // Stall reference: sampled just before each rising edge, where the DUT sees it.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) tb_stall = 0;
      else if (pipe_stall) tb_stall++;
    end
  end

  task automatic if_access(input logic [63:0] addr, input logic [31:0] exp, input int unsigned exp_lat);
    int unsigned c0;
    bit          got;
    if_q.push_back(64'(exp));
    if_addr = addr;
    if_req  = 1'b1;
    c0      = cyc;
    got     = 1'b0;
    for (int unsigned i = 0; i < TMO && !got; i++) begin
      sync();
      if (if_done) got = 1'b1;
    end
    chk("if_done_seen", 64'(got), 64'd1);
    if (got) chk("if_latency", 64'(cyc - c0), 64'(exp_lat));
    if_req = 1'b0;
  endtask

  task automatic dm_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] exp, input int unsigned exp_lat, input bit chk_stall);
    int unsigned c0, st;
    bit          got;
    dm_q.push_back(exp);
    dm_we    = we;
    dm_addr  = addr;
    dm_wdata = wdata;
    dm_req   = 1'b1;
    c0       = cyc;
    st       = 0;
    got      = 1'b0;
    #1;
    if (pipe_stall) st++;
    for (int unsigned i = 0; i < TMO && !got; i++) begin
      sync();
      if (dm_done) got = 1'b1;
      else if (pipe_stall) st++;
    end
    chk("dm_done_seen", 64'(got), 64'd1);
    if (got) chk("dm_latency", 64'(cyc - c0), 64'(exp_lat));
    if (got && chk_stall) begin
      chk("stall_cycles", 64'(st), 64'(MEM_LAT + 1));
      chk("stall_at_done", 64'(pipe_stall), 64'd0);
    end
    dm_req = 1'b0;
    dm_we  = 1'b0;
  endtask

  task automatic dm_burst(input int unsigned n, input logic [63:0] base);
    bit got;
    for (int unsigned k = 0; k < n; k++) dm_q.push_back(64'hA5A5_0000_0000_0000 | 64'(k));
    dm_we  = 1'b0;
    dm_req = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      dm_addr = base + 64'(8 * k);
      got     = 1'b0;
      for (int unsigned i = 0; i < TMO && !got; i++) begin
        sync();
        if (dm_done) got = 1'b1;
      end
      chk("burst_done_seen", 64'(got), 64'd1);
    end
    dm_req = 1'b0;
  endtask

  initial begin
    int unsigned bad;
    for (int unsigned i = 0; i < 256; i++) tb_mem[i] = '0;
    tb_mem[3]  = 64'h0000_0000_0000_1234;
    tb_mem[8]  = 64'h0000_0000_8B02_03E1;
    tb_mem[9]  = 64'h0000_0000_00A0_0093;
    tb_mem[10] = 64'h0000_0000_0000_0013;
    for (int unsigned k = 0; k < 5; k++) tb_mem[32 + k] = 64'hA5A5_0000_0000_0000 | 64'(k);

    rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
    if_addr = 64'h40; dm_addr = 64'h10; dm_wdata = 64'hFFFF;
    #12;
    chk("rst_if_done", 64'(if_done), 64'd0);
    chk("rst_dm_done", 64'(dm_done), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_dm_rdata", dm_rdata, 64'd0);
    chk("rst_pipe_stall", 64'(pipe_stall), 64'd0);
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    sync();
    rst = 1'b1;

    // Reset in the middle of a DM write
    sync();
    order_q.push_back('{we: 1'b1, addr: 64'h10, wdata: 64'hBEEF});
    dm_we = 1'b1; dm_addr = 64'h10; dm_wdata = 64'hBEEF; dm_req = 1'b1;
    sync();
    chk("t1_busy_en", 64'(mem_en), 64'd1);
    chk("t1_busy_we", 64'(mem_we), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("t1_rst_mem_en", 64'(mem_en), 64'd0);
    chk("t1_rst_mem_we", 64'(mem_we), 64'd0);
    chk("t1_rst_dm_done", 64'(dm_done), 64'd0);
    chk("t1_rst_stall", 64'(pipe_stall), 64'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    repeat (2) sync();
    rst = 1'b1;
    bad = 0;
    repeat (4) begin
      sync();
      if (mem_en || dm_done || if_done) bad++;
    end
    chk("t1_idle_after_rst", 64'(bad), 64'd0);

    // Lone IF fetch
    sync();
    order_q.push_back('{we: 1'b0, addr: 64'h40, wdata: 64'h0});
    if_access(64'h40, 32'h8B02_03E1, MEM_LAT + 1);

    // Simultaneous DM write and IF fetch
    sync();
    start_q.delete();
    order_q.push_back('{we: 1'b1, addr: 64'h10, wdata: 64'hDEAD});
    order_q.push_back('{we: 1'b0, addr: 64'h48, wdata: 64'h0});
    fork
      dm_access(1'b1, 64'h10, 64'hDEAD, 64'h0, MEM_LAT + 1, 1'b0);
      if_access(64'h48, 32'h00A0_0093, 2 * (MEM_LAT + 1));
    join
    chk("t3_access_cnt", 64'(start_q.size()), 64'd2);
    if (start_q.size() >= 2) chk("t3_no_bubble", 64'(start_q[1] - start_q[0]), 64'(MEM_LAT + 1));

    // DM held for 5 accesses against a pending IF: IF forced in after STARVE_LIM losses
    sync();
    for (int unsigned k = 0; k < 4; k++)
      order_q.push_back('{we: 1'b0, addr: 64'h100 + 64'(8 * k), wdata: 64'h0});
    order_q.push_back('{we: 1'b0, addr: 64'h50, wdata: 64'h0});
    order_q.push_back('{we: 1'b0, addr: 64'h120, wdata: 64'h0});
    fork
      dm_burst(5, 64'h100);
      if_access(64'h50, 32'h0000_0013, (STARVE_LIM + 1) * (MEM_LAT + 1));
    join
    chk("t4_order_drained", 64'(order_q.size()), 64'd0);
    sync();
`ifdef ARB_PERF_EN
    chk("perf_if_starve", 64'(perf_if_starve), 64'd1);
    chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(tb_stall));
`endif

    // DM reads: preloaded word with stall profile, then the word written earlier
    sync();
    order_q.push_back('{we: 1'b0, addr: 64'h18, wdata: 64'h0});
    dm_access(1'b0, 64'h18, 64'h0, 64'h1234, MEM_LAT + 1, 1'b1);
    sync();
    order_q.push_back('{we: 1'b0, addr: 64'h10, wdata: 64'h0});
    dm_access(1'b0, 64'h10, 64'h0, 64'hDEAD, MEM_LAT + 1, 1'b0);

    repeat (3) sync();
    chk("queues_drained", 64'(if_q.size() + dm_q.size() + order_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
